// File: rtl/id_pool_nwmr.sv
// id_pool_nwmr: multi-lane FIFO free-list of transaction IDs.
// Up to N_WR IDs are released and up to N_RD IDs are allocated per cycle.
// IDs leave in the same order they entered. All pointers wrap modulo DEPTH,
// so DEPTH does not have to be a power of two.
//
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   c_srdy  - release lane valid                   [N_WR]
//   c_drdy  - release lane accepted (combinational) [N_WR]
//   c_data  - released IDs                          [N_WR][WIDTH]
//   p_srdy  - allocate lane holds an ID             [N_RD]
//   p_drdy  - consumer takes the lane's ID          [N_RD]
//   p_data  - IDs offered on the allocate lanes     [N_RD][WIDTH]
//   usage   - number of IDs held in the pool        [PTR_W+1]
//   empty   - usage == 0
//   full    - usage == DEPTH
//   low_wm  - usage <= LOW_WM
module id_pool_nwmr #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N_WR     = 2,
    parameter int unsigned N_RD     = 2,
    parameter int unsigned INIT_CNT = DEPTH,
    parameter int unsigned LOW_WM   = 1,
    parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_WR-1:0]            c_srdy,
    output logic [N_WR-1:0]            c_drdy,
    input  logic [N_WR-1:0][WIDTH-1:0] c_data,
    output logic [N_RD-1:0]            p_srdy,
    input  logic [N_RD-1:0]            p_drdy,
    output logic [N_RD-1:0][WIDTH-1:0] p_data,
    output logic [PTR_W:0]             usage,
    output logic                       empty,
    output logic                       full,
    output logic                       low_wm
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = PTR_W + 2;

    logic [WIDTH-1:0] r_array [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_pop_cnt;
    logic [CNT_W-1:0] w_push_cnt;
    logic [N_WR-1:0]  w_push;
    logic [CNT_W-1:0] w_wr_off [N_WR];
    logic [SUM_W-1:0] w_cnt_sum;

    // base + off modulo DEPTH; off never exceeds DEPTH, so one subtraction suffices
    function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base,
                                                 input logic [CNT_W-1:0] off);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(off);
        if (sum >= SUM_W'(DEPTH)) begin
            sum = sum - SUM_W'(DEPTH);
        end
        return PTR_W'(sum);
    endfunction

    // Allocate lanes present the next N_RD IDs straight from storage
    always_comb begin
        p_srdy = '0;
        p_data = '0;
        for (int j = 0; j < N_RD; j++) begin
            p_srdy[j] = (r_cnt > CNT_W'(j));
            p_data[j] = r_array[f_wrap(r_rd_ptr, CNT_W'(j))];
        end
    end

    // Pop count: only the unbroken run of taken lanes starting at lane 0
    always_comb begin : pop_count_c
        logic run;
        run       = 1'b1;
        w_pop_cnt = '0;
        for (int j = 0; j < N_RD; j++) begin
            if (run && p_srdy[j] && p_drdy[j]) begin
                w_pop_cnt = w_pop_cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Room comes from the registered count only; same-cycle pops do not help
    assign w_free = CNT_W'(DEPTH) - r_cnt;

    // Release lanes: lane i is granted if fewer than 'free' lower lanes are requesting.
    // A granted lane's write offset equals the number of requesting lanes below it.
    always_comb begin : push_c
        logic [CNT_W-1:0] seen;
        seen       = '0;
        w_push_cnt = '0;
        w_push     = '0;
        c_drdy     = '0;
        for (int i = 0; i < N_WR; i++) begin
            w_wr_off[i] = seen;
            c_drdy[i]   = (seen < w_free);
            w_push[i]   = c_srdy[i] & c_drdy[i];
            if (w_push[i]) begin
                w_push_cnt = w_push_cnt + CNT_W'(1);
            end
            if (c_srdy[i]) begin
                seen = seen + CNT_W'(1);
            end
        end
    end

    assign w_cnt_sum = SUM_W'(r_cnt) + SUM_W'(w_push_cnt) - SUM_W'(w_pop_cnt);

    assign usage  = r_cnt;
    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == CNT_W'(DEPTH));
    assign low_wm = (r_cnt <= CNT_W'(LOW_WM));

    // Pool state: pointers, count and ID storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= PTR_W'(INIT_CNT % DEPTH);
            r_cnt    <= CNT_W'(INIT_CNT);
            for (int i = 0; i < DEPTH; i++) begin
                r_array[i] <= (i < INIT_CNT) ? WIDTH'(i) : '0;
            end
        end else begin
            r_rd_ptr <= f_wrap(r_rd_ptr, w_pop_cnt);
            r_wr_ptr <= f_wrap(r_wr_ptr, w_push_cnt);
            r_cnt    <= CNT_W'(w_cnt_sum);
            for (int i = 0; i < N_WR; i++) begin
                if (w_push[i]) begin
                    r_array[f_wrap(r_wr_ptr, w_wr_off[i])] <= c_data[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_id_pool_nwmr.sv
// Self-checking bench for id_pool_nwmr: directed scenarios on a default
// instance (DEPTH=8) and a non-power-of-two instance (DEPTH=6, INIT_CNT=4),
// plus randomized traffic checked against a queue-based reference model.
module tb_id_pool_nwmr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, rst_b;
    logic [1:0]      c_srdy, p_drdy;
    logic [1:0][7:0] c_data;

    logic [1:0]      c_drdy_a, c_drdy_b, p_srdy_a, p_srdy_b;
    logic [1:0][7:0] p_data_a, p_data_b;
    logic [3:0]      usage_a, usage_b;
    logic            empty_a, empty_b, full_a, full_b, low_wm_a, low_wm_b;

    int cur;
    int checks;
    int errors;

    id_pool_nwmr u_dut_a (
        .clk(clk), .rst(rst_a),
        .c_srdy(c_srdy), .c_drdy(c_drdy_a), .c_data(c_data),
        .p_srdy(p_srdy_a), .p_drdy(p_drdy), .p_data(p_data_a),
        .usage(usage_a), .empty(empty_a), .full(full_a), .low_wm(low_wm_a)
    );

    id_pool_nwmr #(.DEPTH(6), .INIT_CNT(4)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .c_srdy(c_srdy), .c_drdy(c_drdy_b), .c_data(c_data),
        .p_srdy(p_srdy_b), .p_drdy(p_drdy), .p_data(p_data_b),
        .usage(usage_b), .empty(empty_b), .full(full_b), .low_wm(low_wm_b)
    );

    // Observed outputs of whichever instance is under test
    logic [1:0]      o_c_drdy, o_p_srdy;
    logic [1:0][7:0] o_p_data;
    logic [3:0]      o_usage;
    logic            o_empty, o_full, o_low_wm;
    assign o_c_drdy = (cur != 0) ? c_drdy_b : c_drdy_a;
    assign o_p_srdy = (cur != 0) ? p_srdy_b : p_srdy_a;
    assign o_p_data = (cur != 0) ? p_data_b : p_data_a;
    assign o_usage  = (cur != 0) ? usage_b  : usage_a;
    assign o_empty  = (cur != 0) ? empty_b  : empty_a;
    assign o_full   = (cur != 0) ? full_b   : full_a;
    assign o_low_wm = (cur != 0) ? low_wm_b : low_wm_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset the selected instance for 2 cycles; the other stays held in reset
    task automatic do_reset(input int sel);
        cur    = sel;
        c_srdy = '0;
        p_drdy = '0;
        c_data = '0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        tick();
        tick();
        if (sel != 0) rst_b = 1'b0; else rst_a = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++; if (o_usage !== 4'd8) begin errors++; $display("FAIL rst_usage got %0d exp 8", o_usage); end
        checks++; if (o_full !== 1'b1 || o_empty !== 1'b0 || o_low_wm !== 1'b0) begin errors++; $display("FAIL rst_flags got full=%b empty=%b low_wm=%b exp 1 0 0", o_full, o_empty, o_low_wm); end
        checks++; if (o_p_srdy !== 2'b11) begin errors++; $display("FAIL rst_p_srdy got %b exp 11", o_p_srdy); end
        checks++; if (o_p_data[0] !== 8'd0 || o_p_data[1] !== 8'd1) begin errors++; $display("FAIL rst_p_data got %0d,%0d exp 0,1", o_p_data[0], o_p_data[1]); end
        c_srdy = 2'b11;
        #1;
        checks++; if (o_c_drdy !== 2'b00) begin errors++; $display("FAIL rst_c_drdy_full got %b exp 00", o_c_drdy); end
        c_srdy = 2'b00;
    endtask

    task automatic test_drain();
        do_reset(0);
        p_drdy = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (o_p_srdy !== 2'b11 || o_p_data[0] !== 8'(2*c) || o_p_data[1] !== 8'(2*c+1)) begin errors++; $display("FAIL drain_pair%0d got srdy=%b %0d,%0d exp 11 %0d,%0d", c, o_p_srdy, o_p_data[0], o_p_data[1], 2*c, 2*c+1); end
            tick();
        end
        p_drdy = 2'b00;
        checks++; if (o_usage !== 4'd0 || o_empty !== 1'b1 || o_low_wm !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL drain_empty got usage=%0d empty=%b low_wm=%b full=%b exp 0 1 1 0", o_usage, o_empty, o_low_wm, o_full); end
        checks++; if (o_p_srdy !== 2'b00) begin errors++; $display("FAIL drain_p_srdy got %b exp 00", o_p_srdy); end
        // Read pointer must be back at slot 0, where the next release lands
        c_srdy = 2'b01;
        c_data = {8'h00, 8'h99};
        #1;
        checks++; if (o_c_drdy[0] !== 1'b1) begin errors++; $display("FAIL drain_release_drdy got %b exp 1", o_c_drdy[0]); end
        tick();
        c_srdy = 2'b00;
        checks++; if (o_usage !== 4'd1 || o_p_data[0] !== 8'h99 || o_p_srdy !== 2'b01) begin errors++; $display("FAIL drain_wrap got usage=%0d data=%0h srdy=%b exp 1 99 01", o_usage, o_p_data[0], o_p_srdy); end
    endtask

    task automatic test_partial_room();
        logic [7:0] exp_ids [8];
        do_reset(0);
        p_drdy = 2'b01;
        tick();
        p_drdy = 2'b00;
        checks++; if (o_usage !== 4'd7 || o_low_wm !== 1'b0) begin errors++; $display("FAIL room_usage7 got %0d exp 7", o_usage); end
        c_srdy = 2'b10;
        c_data = {8'h20, 8'h11};
        #1;
        checks++; if ((o_c_drdy & c_srdy) !== 2'b10 || o_c_drdy[1] !== 1'b1) begin errors++; $display("FAIL room_lane1 got c_drdy=%b exp lane1 accepted", o_c_drdy); end
        tick();
        c_srdy = 2'b00;
        checks++; if (o_usage !== 4'd8 || o_full !== 1'b1) begin errors++; $display("FAIL room_lane1_usage got %0d exp 8", o_usage); end
        p_drdy = 2'b01;
        tick();
        p_drdy = 2'b00;
        c_srdy = 2'b11;
        c_data = {8'h31, 8'h30};
        #1;
        checks++; if (o_c_drdy !== 2'b01) begin errors++; $display("FAIL room_two_lanes got c_drdy=%b exp 01", o_c_drdy); end
        tick();
        c_srdy = 2'b00;
        checks++; if (o_usage !== 4'd8) begin errors++; $display("FAIL room_two_usage got %0d exp 8", o_usage); end
        exp_ids = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'h20, 8'h30};
        p_drdy = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (o_p_data[0] !== exp_ids[2*c] || o_p_data[1] !== exp_ids[2*c+1]) begin errors++; $display("FAIL room_order%0d got %0h,%0h exp %0h,%0h", c, o_p_data[0], o_p_data[1], exp_ids[2*c], exp_ids[2*c+1]); end
            tick();
        end
        p_drdy = 2'b00;
    endtask

    task automatic test_simul_empty_edge();
        do_reset(0);
        p_drdy = 2'b11;
        repeat (4) tick();
        p_drdy = 2'b00;
        c_srdy = 2'b01;
        c_data = {8'h00, 8'h05};
        tick();
        c_srdy = 2'b00;
        checks++; if (o_usage !== 4'd1 || o_p_srdy !== 2'b01 || o_p_data[0] !== 8'd5) begin errors++; $display("FAIL simul_setup got usage=%0d srdy=%b data=%0d exp 1 01 5", o_usage, o_p_srdy, o_p_data[0]); end
        c_srdy = 2'b11;
        c_data = {8'd4, 8'd3};
        p_drdy = 2'b11;
        #1;
        checks++; if (o_c_drdy !== 2'b11 || o_p_srdy !== 2'b01) begin errors++; $display("FAIL simul_hs got c_drdy=%b p_srdy=%b exp 11 01", o_c_drdy, o_p_srdy); end
        tick();
        c_srdy = 2'b00;
        p_drdy = 2'b00;
        checks++; if (o_usage !== 4'd2 || o_p_srdy !== 2'b11 || o_p_data[0] !== 8'd3 || o_p_data[1] !== 8'd4) begin errors++; $display("FAIL simul_after got usage=%0d srdy=%b %0d,%0d exp 2 11 3,4", o_usage, o_p_srdy, o_p_data[0], o_p_data[1]); end
    endtask

    task automatic test_gap();
        do_reset(0);
        p_drdy = 2'b10;
        tick();
        p_drdy = 2'b00;
        checks++; if (o_usage !== 4'd8 || o_p_data[0] !== 8'd0 || o_p_data[1] !== 8'd1) begin errors++; $display("FAIL gap got usage=%0d %0d,%0d exp 8 0,1", o_usage, o_p_data[0], o_p_data[1]); end
    endtask

    task automatic test_np2();
        logic [7:0] exp_ids [6];
        do_reset(1);
        checks++; if (o_usage !== 4'd4 || o_full !== 1'b0 || o_empty !== 1'b0 || o_p_srdy !== 2'b11) begin errors++; $display("FAIL np2_rst got usage=%0d full=%b srdy=%b exp 4 0 11", o_usage, o_full, o_p_srdy); end
        checks++; if (o_p_data[0] !== 8'd0 || o_p_data[1] !== 8'd1) begin errors++; $display("FAIL np2_rst_data got %0d,%0d exp 0,1", o_p_data[0], o_p_data[1]); end
        c_srdy = 2'b11;
        c_data = {8'h41, 8'h40};
        p_drdy = 2'b01;
        #1;
        checks++; if (o_c_drdy !== 2'b11 || o_p_data[0] !== 8'd0) begin errors++; $display("FAIL np2_rel2 got c_drdy=%b head=%0d exp 11 0", o_c_drdy, o_p_data[0]); end
        tick();
        p_drdy = 2'b00;
        c_srdy = 2'b01;
        c_data = {8'h00, 8'h42};
        #1;
        checks++; if (o_usage !== 4'd5 || o_c_drdy[0] !== 1'b1) begin errors++; $display("FAIL np2_rel1 got usage=%0d c_drdy=%b exp 5 x1", o_usage, o_c_drdy); end
        tick();
        c_srdy = 2'b00;
        checks++; if (o_usage !== 4'd6 || o_full !== 1'b1) begin errors++; $display("FAIL np2_full got usage=%0d full=%b exp 6 1", o_usage, o_full); end
        exp_ids = '{8'd1, 8'd2, 8'd3, 8'h40, 8'h41, 8'h42};
        p_drdy = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (o_p_data[0] !== exp_ids[2*c] || o_p_data[1] !== exp_ids[2*c+1]) begin errors++; $display("FAIL np2_order%0d got %0h,%0h exp %0h,%0h", c, o_p_data[0], o_p_data[1], exp_ids[2*c], exp_ids[2*c+1]); end
            tick();
        end
        p_drdy = 2'b00;
        checks++; if (o_empty !== 1'b1 || o_usage !== 4'd0) begin errors++; $display("FAIL np2_empty got usage=%0d exp 0", o_usage); end
    endtask

    // Random traffic against a queue model; includes occasional mid-run resets
    task automatic test_random(input int sel, input int depth, input int init, input int n);
        int         q[$];
        int         sz, free, seen, k;
        logic       rs;
        logic [1:0] exp_drdy, exp_psrdy;
        do_reset(sel);
        for (int i = 0; i < init; i++) q.push_back(i);
        for (int c = 0; c < n; c++) begin
            rs     = ($urandom_range(0, 49) == 0);
            c_srdy = 2'($urandom);
            c_data = 16'($urandom);
            p_drdy = 2'($urandom);
            if (sel != 0) rst_b = rs; else rst_a = rs;
            #1;
            sz   = q.size();
            free = depth - sz;
            seen = 0;
            for (int i = 0; i < 2; i++) begin
                exp_drdy[i]  = (seen < free);
                exp_psrdy[i] = (sz > i);
                if (c_srdy[i]) seen++;
            end
            checks++; if (o_usage !== 4'(sz)) begin errors++; $display("FAIL rnd%0d_usage cyc %0d got %0d exp %0d", sel, c, o_usage, sz); end
            checks++; if (o_empty !== (sz == 0) || o_full !== (sz == depth) || o_low_wm !== (sz <= 1)) begin errors++; $display("FAIL rnd%0d_flags cyc %0d got e=%b f=%b l=%b size %0d", sel, c, o_empty, o_full, o_low_wm, sz); end
            checks++; if (o_p_srdy !== exp_psrdy) begin errors++; $display("FAIL rnd%0d_p_srdy cyc %0d got %b exp %b", sel, c, o_p_srdy, exp_psrdy); end
            for (int j = 0; j < 2; j++) begin
                if (j < sz) begin
                    checks++; if (o_p_data[j] !== 8'(q[j])) begin errors++; $display("FAIL rnd%0d_p_data%0d cyc %0d got %0h exp %0h", sel, j, c, o_p_data[j], 8'(q[j])); end
                end
            end
            if (!rs) begin
                checks++; if (o_c_drdy !== exp_drdy) begin errors++; $display("FAIL rnd%0d_c_drdy cyc %0d got %b exp %b", sel, c, o_c_drdy, exp_drdy); end
            end
            if (rs) begin
                q.delete();
                for (int i = 0; i < init; i++) q.push_back(i);
            end else begin
                k = 0;
                while (k < 2 && k < sz && p_drdy[k]) k++;
                for (int i = 0; i < k; i++) void'(q.pop_front());
                for (int i = 0; i < 2; i++) begin
                    if (c_srdy[i] && exp_drdy[i]) q.push_back(int'(c_data[i]));
                end
            end
            tick();
        end
        if (sel != 0) rst_b = 1'b0; else rst_a = 1'b0;
        c_srdy = '0;
        p_drdy = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cur    = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        c_srdy = '0;
        p_drdy = '0;
        c_data = '0;
        test_reset();
        test_drain();
        test_partial_room();
        test_simul_empty_edge();
        test_gap();
        test_random(0, 8, 8, 400);
        test_np2();
        test_random(1, 6, 4, 400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
